// File: rtl/nios2_ocimem_pkg.sv
// nios2_ocimem_pkg
// Shared types and default sizes for the OCI RAM arbiter slice.
//   state_e       : arbiter FSM states (IDLE, RD_CPU, RD_JTAG)
//   grant_e       : which requester won the last arbitration
//   DEF_ADDR_W    : default RAM word-address width (256 words)
//   DEF_DATA_W    : default data width (multiple of 8)
//   DEF_PROT_BASE : default first CPU write-protected word address
package nios2_ocimem_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;
  localparam int unsigned DEF_PROT_BASE = 32'hE0;

  typedef enum logic [1:0] {
    IDLE,
    RD_CPU,
    RD_JTAG
  } state_e;

  typedef enum logic {
    GNT_CPU,
    GNT_JTAG
  } grant_e;

endpackage

// File: rtl/nios2_ocimem_ram.sv
// nios2_ocimem_ram
// Single-port synchronous OCI RAM: one-cycle read latency, per-byte write
// enables, contents are not reset. A read during a write returns old data.
// Ports:
//   clk   : CPU clock
//   addr  : word address
//   wdata : write data
//   be    : byte enables (one per 8 data bits)
//   we    : write enable
//   q     : registered read data for the address of the previous cycle
module nios2_ocimem_ram
  import nios2_ocimem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                  clk,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   be,
  input  logic                  we,
  output logic [DATA_W-1:0]     q
);

  localparam int BE_W = DATA_W / 8;

  logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) begin
          mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
    q <= mem[addr];
  end

endmodule

// File: rtl/nios2_ocimem_arbiter.sv
// nios2_ocimem_arbiter
// Shares the single-port OCI RAM between the JTAG debug path (auto-increment
// pointer, single-entry pending slot) and the CPU debug-monitor data master
// (Avalon-MM waitrequest/readdatavalid). Round-robin arbitration in IDLE.
// Optional build macro: OCIMEM_CPU_WR_PROTECT_EN -- CPU writes at or above
// PROT_BASE are accepted but dropped, and set sticky cpu_wr_err.
// Ports:
//   clk, reset            : CPU clock, async active-high reset
//   jtag_set_addr/addr    : load JTAG pointer, clear jtag_overrun
//   jtag_rd/wr/wdata      : JTAG read/write pulses at the pointer
//   mon_dreg              : last JTAG read data
//   jtag_done             : one-cycle JTAG completion pulse
//   jtag_overrun          : sticky, JTAG op dropped because slot was full
//   cpu_*                 : Avalon-MM slave for the CPU
//   cpu_wr_err            : sticky CPU protect violation (0 when disabled)
module nios2_ocimem_arbiter
  import nios2_ocimem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
`ifdef OCIMEM_CPU_WR_PROTECT_EN
  ,
  parameter int unsigned PROT_BASE = DEF_PROT_BASE
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  jtag_set_addr,
  input  logic [ADDR_W-1:0]     jtag_addr,
  input  logic                  jtag_rd,
  input  logic                  jtag_wr,
  input  logic [DATA_W-1:0]     jtag_wdata,
  output logic [DATA_W-1:0]     mon_dreg,
  output logic                  jtag_done,
  output logic                  jtag_overrun,
  input  logic                  cpu_read,
  input  logic                  cpu_write,
  input  logic [ADDR_W-1:0]     cpu_address,
  input  logic [DATA_W-1:0]     cpu_writedata,
  input  logic [DATA_W/8-1:0]   cpu_byteenable,
  output logic                  cpu_waitrequest,
  output logic [DATA_W-1:0]     cpu_readdata,
  output logic                  cpu_readdatavalid,
  output logic                  cpu_wr_err
);

  state_e              state;
  grant_e              last_grant;
  logic [ADDR_W-1:0]   ptr;
  logic                pend_valid;
  logic                pend_wr;
  logic [DATA_W-1:0]   pend_wdata;
  logic [DATA_W-1:0]   cpu_rd_hold;

  logic                cpu_req;
  logic                jtag_pulse;
  logic                gnt_cpu;
  logic                gnt_jtag;
  logic                ptr_inc;
  logic                prot_hit;

  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_wdata;
  logic [DATA_W/8-1:0] ram_be;
  logic                ram_we;
  logic [DATA_W-1:0]   ram_q;

`ifdef OCIMEM_CPU_WR_PROTECT_EN
  assign prot_hit = (cpu_address >= ADDR_W'(PROT_BASE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_wr_err <= 1'b0;
    end else if (gnt_cpu && cpu_write && prot_hit) begin
      cpu_wr_err <= 1'b1;
    end
  end
`else
  assign prot_hit   = 1'b0;
  assign cpu_wr_err = 1'b0;
`endif

  // Grants only exist in IDLE; on a tie the side that did not win last goes.
  always_comb begin
    cpu_req    = cpu_read | cpu_write;
    jtag_pulse = jtag_rd | jtag_wr;
    gnt_cpu    = (state == IDLE) & cpu_req &
                 (~pend_valid | (last_grant == GNT_JTAG));
    gnt_jtag   = (state == IDLE) & pend_valid &
                 (~cpu_req | (last_grant == GNT_CPU));
    ptr_inc    = (gnt_jtag & pend_wr) | (state == RD_JTAG);
  end

  // RAM port mux; JTAG always writes whole words.
  always_comb begin
    ram_addr  = ptr;
    ram_wdata = pend_wdata;
    ram_be    = '1;
    ram_we    = 1'b0;
    if (gnt_cpu) begin
      ram_addr  = cpu_address;
      ram_wdata = cpu_writedata;
      ram_be    = cpu_byteenable;
      ram_we    = cpu_write & ~prot_hit;
    end else if (gnt_jtag) begin
      ram_we    = pend_wr;
    end
  end

  // Read data is presented straight from the RAM in RD_CPU so that the
  // strobe lands one cycle after acceptance; the hold register keeps it.
  assign cpu_waitrequest   = reset | ~gnt_cpu;
  assign cpu_readdatavalid = (state == RD_CPU);
  assign cpu_readdata      = (state == RD_CPU) ? ram_q : cpu_rd_hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      last_grant   <= GNT_CPU;
      ptr          <= '0;
      pend_valid   <= 1'b0;
      pend_wr      <= 1'b0;
      pend_wdata   <= '0;
      cpu_rd_hold  <= '0;
      mon_dreg     <= '0;
      jtag_done    <= 1'b0;
      jtag_overrun <= 1'b0;
    end else begin
      jtag_done <= 1'b0;

      // A pulse into a full slot is dropped; the slot is never being filled
      // and freed in the same cycle because fills need it empty.
      if (jtag_pulse && pend_valid) begin
        jtag_overrun <= 1'b1;
      end else if (jtag_set_addr) begin
        jtag_overrun <= 1'b0;
      end
      if (jtag_pulse && !pend_valid) begin
        pend_valid <= 1'b1;
        pend_wr    <= jtag_wr;
        pend_wdata <= jtag_wdata;
      end

      // A pointer load wins over a completing access's increment.
      if (jtag_set_addr) begin
        ptr <= jtag_addr;
      end else if (ptr_inc) begin
        ptr <= ptr + 1'b1;
      end

      case (state)
        IDLE: begin
          if (gnt_cpu) begin
            last_grant <= GNT_CPU;
            if (!cpu_write) begin
              state <= RD_CPU;
            end
          end else if (gnt_jtag) begin
            last_grant <= GNT_JTAG;
            if (pend_wr) begin
              jtag_done  <= 1'b1;
              pend_valid <= 1'b0;
            end else begin
              state <= RD_JTAG;
            end
          end
        end
        RD_CPU: begin
          cpu_rd_hold <= ram_q;
          state       <= IDLE;
        end
        RD_JTAG: begin
          mon_dreg   <= ram_q;
          jtag_done  <= 1'b1;
          pend_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  nios2_ocimem_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .be    (ram_be),
    .we    (ram_we),
    .q     (ram_q)
  );

endmodule

// File: tb/tb_nios2_ocimem_arbiter.sv
// tb_nios2_ocimem_arbiter
// Directed self-checking bench for nios2_ocimem_arbiter. Inputs change on the
// falling clock edge; outputs are sampled 1 ns later, mid-cycle.
module tb_nios2_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        jtag_set_addr = 1'b0;
  logic [7:0]  jtag_addr = '0;
  logic        jtag_rd = 1'b0;
  logic        jtag_wr = 1'b0;
  logic [31:0] jtag_wdata = '0;
  logic [31:0] mon_dreg;
  logic        jtag_done;
  logic        jtag_overrun;
  logic        cpu_read = 1'b0;
  logic        cpu_write = 1'b0;
  logic [7:0]  cpu_address = '0;
  logic [31:0] cpu_writedata = '0;
  logic [3:0]  cpu_byteenable = '0;
  logic        cpu_waitrequest;
  logic [31:0] cpu_readdata;
  logic        cpu_readdatavalid;
  logic        cpu_wr_err;

  int n_compared = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  nios2_ocimem_arbiter dut (
    .clk               (clk),
    .reset             (reset),
    .jtag_set_addr     (jtag_set_addr),
    .jtag_addr         (jtag_addr),
    .jtag_rd           (jtag_rd),
    .jtag_wr           (jtag_wr),
    .jtag_wdata        (jtag_wdata),
    .mon_dreg          (mon_dreg),
    .jtag_done         (jtag_done),
    .jtag_overrun      (jtag_overrun),
    .cpu_read          (cpu_read),
    .cpu_write         (cpu_write),
    .cpu_address       (cpu_address),
    .cpu_writedata     (cpu_writedata),
    .cpu_byteenable    (cpu_byteenable),
    .cpu_waitrequest   (cpu_waitrequest),
    .cpu_readdata      (cpu_readdata),
    .cpu_readdatavalid (cpu_readdatavalid),
    .cpu_wr_err        (cpu_wr_err)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Drives one cycle of inputs on the falling edge, then waits 1 ns.
  task automatic applyStimulus(input logic set, input logic [7:0] a,
                               input logic rd, input logic wr,
                               input logic [31:0] wd,
                               input logic crd, input logic cwr,
                               input logic [7:0] ca, input logic [31:0] cwd,
                               input logic [3:0] cbe);
    @(negedge clk);
    jtag_set_addr  = set;
    jtag_addr      = a;
    jtag_rd        = rd;
    jtag_wr        = wr;
    jtag_wdata     = wd;
    cpu_read       = crd;
    cpu_write      = cwr;
    cpu_address    = ca;
    cpu_writedata  = cwd;
    cpu_byteenable = cbe;
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
  endtask

  // One JTAG op; jtag_done must appear exactly lat cycles after the pulse.
  task automatic jtagAccess(input logic set, input logic [7:0] a,
                            input logic rd, input logic [31:0] wd,
                            input int lat, input string tag);
    applyStimulus(set, a, rd, ~rd, wd, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    for (int k = 1; k <= lat; k++) begin
      idleCycle();
      checkOutput(tag, {31'b0, jtag_done}, {31'b0, k == lat});
    end
  endtask

  task automatic cpuWrite(input logic [7:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input string tag);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, a, wd, be);
    checkOutput(tag, {31'b0, cpu_waitrequest}, 32'h0);
  endtask

  initial begin
    $display("[TB] start");
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_waitreq", {31'b0, cpu_waitrequest}, 32'h1);
    checkOutput("rst_mon_dreg", mon_dreg, 32'h0);
    checkOutput("rst_readdata", cpu_readdata, 32'h0);
    checkOutput("rst_rdvalid", {31'b0, cpu_readdatavalid}, 32'h0);
    checkOutput("rst_done", {31'b0, jtag_done}, 32'h0);
    checkOutput("rst_overrun", {31'b0, jtag_overrun}, 32'h0);
    checkOutput("rst_wr_err", {31'b0, cpu_wr_err}, 32'h0);
    reset = 1'b0;

    // JTAG write/write/read/read with pointer auto-increment.
    jtagAccess(1'b1, 8'h10, 1'b0, 32'hDEADBEEF, 2, "jw10_done");
    jtagAccess(1'b0, 8'h00, 1'b0, 32'hCAFEF00D, 2, "jw11_done");
    jtagAccess(1'b1, 8'h10, 1'b1, 32'h0, 3, "jr10_done");
    checkOutput("jr10_data", mon_dreg, 32'hDEADBEEF);
    jtagAccess(1'b0, 8'h00, 1'b1, 32'h0, 3, "jr11_done");
    checkOutput("jr11_data", mon_dreg, 32'hCAFEF00D);

    // CPU byte-enabled write then read with one-cycle readdatavalid.
    cpuWrite(8'h20, 32'h00000000, 4'b1111, "cw_clr_wait");
    cpuWrite(8'h20, 32'h12345678, 4'b0011, "cw_be_wait");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 8'h20, 32'h0, 4'h0);
    checkOutput("cr_accept", {31'b0, cpu_waitrequest}, 32'h0);
    checkOutput("cr_noval0", {31'b0, cpu_readdatavalid}, 32'h0);
    idleCycle();
    checkOutput("cr_valid", {31'b0, cpu_readdatavalid}, 32'h1);
    checkOutput("cr_data", cpu_readdata, 32'h00005678);
    idleCycle();
    checkOutput("cr_valid_off", {31'b0, cpu_readdatavalid}, 32'h0);
    checkOutput("cr_hold", cpu_readdata, 32'h00005678);

    // Contention: JTAG, CPU, JTAG, CPU with CPU read held.
    applyStimulus(1'b1, 8'h10, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 8'h20, 32'h0, 4'h0);
    checkOutput("arb1_wait", {31'b0, cpu_waitrequest}, 32'h1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 8'h20, 32'h0, 4'h0);
    checkOutput("arb2_wait", {31'b0, cpu_waitrequest}, 32'h1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 8'h20, 32'h0, 4'h0);
    checkOutput("arb3_wait", {31'b0, cpu_waitrequest}, 32'h0);
    checkOutput("arb3_done", {31'b0, jtag_done}, 32'h1);
    checkOutput("arb3_mon", mon_dreg, 32'hDEADBEEF);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 8'h20, 32'h0, 4'h0);
    checkOutput("arb4_valid", {31'b0, cpu_readdatavalid}, 32'h1);
    checkOutput("arb4_data", cpu_readdata, 32'h00005678);
    checkOutput("arb4_wait", {31'b0, cpu_waitrequest}, 32'h1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 8'h20, 32'h0, 4'h0);
    checkOutput("arb5_wait", {31'b0, cpu_waitrequest}, 32'h1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 8'h20, 32'h0, 4'h0);
    checkOutput("arb6_wait", {31'b0, cpu_waitrequest}, 32'h1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 8'h20, 32'h0, 4'h0);
    checkOutput("arb7_wait", {31'b0, cpu_waitrequest}, 32'h0);
    checkOutput("arb7_done", {31'b0, jtag_done}, 32'h1);
    checkOutput("arb7_mon", mon_dreg, 32'hCAFEF00D);
    idleCycle();
    checkOutput("arb8_valid", {31'b0, cpu_readdatavalid}, 32'h1);
    idleCycle();

    // Overrun: second write pulse while the slot is full is dropped.
    applyStimulus(1'b1, 8'h30, 1'b0, 1'b1, 32'h11111111, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 32'h22222222, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    checkOutput("ovr_pre", {31'b0, jtag_overrun}, 32'h0);
    idleCycle();
    checkOutput("ovr_set", {31'b0, jtag_overrun}, 32'h1);
    checkOutput("ovr_done1", {31'b0, jtag_done}, 32'h1);
    idleCycle();
    checkOutput("ovr_drop", {31'b0, jtag_done}, 32'h0);
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    checkOutput("ovr_sticky", {31'b0, jtag_overrun}, 32'h1);
    idleCycle();
    checkOutput("ovr_clear", {31'b0, jtag_overrun}, 32'h0);

    // Pointer wrap from 8'hFF to 8'h00.
    jtagAccess(1'b1, 8'hFF, 1'b0, 32'hAAAA0001, 2, "wrap_w0");
    jtagAccess(1'b0, 8'h00, 1'b0, 32'hAAAA0002, 2, "wrap_w1");
    jtagAccess(1'b1, 8'hFF, 1'b1, 32'h0, 3, "wrap_r0");
    checkOutput("wrap_ff", mon_dreg, 32'hAAAA0001);
    jtagAccess(1'b0, 8'h00, 1'b1, 32'h0, 3, "wrap_r1");
    checkOutput("wrap_inc", mon_dreg, 32'hAAAA0002);
    jtagAccess(1'b1, 8'h00, 1'b1, 32'h0, 3, "wrap_r2");
    checkOutput("wrap_00", mon_dreg, 32'hAAAA0002);

    // CPU write into the protectable region; JTAG is never protected.
    jtagAccess(1'b1, 8'hE5, 1'b0, 32'h5A5A5A5A, 2, "prot_jw");
    cpuWrite(8'hE5, 32'h11223344, 4'b1111, "prot_cw_wait");
    idleCycle();
`ifdef OCIMEM_CPU_WR_PROTECT_EN
    checkOutput("prot_err", {31'b0, cpu_wr_err}, 32'h1);
    jtagAccess(1'b1, 8'hE5, 1'b1, 32'h0, 3, "prot_jr");
    checkOutput("prot_data", mon_dreg, 32'h5A5A5A5A);
`else
    checkOutput("prot_err", {31'b0, cpu_wr_err}, 32'h0);
    jtagAccess(1'b1, 8'hE5, 1'b1, 32'h0, 3, "prot_jr");
    checkOutput("prot_data", mon_dreg, 32'h11223344);
`endif

    // Reset during RD_CPU: no strobe, outputs back to reset values.
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 8'h20, 32'h0, 4'h0);
    checkOutput("rrst_accept", {31'b0, cpu_waitrequest}, 32'h0);
    @(negedge clk);
    reset    = 1'b1;
    cpu_read = 1'b0;
    #1;
    checkOutput("rrst_valid", {31'b0, cpu_readdatavalid}, 32'h0);
    checkOutput("rrst_rdata", cpu_readdata, 32'h0);
    checkOutput("rrst_mon", mon_dreg, 32'h0);
    checkOutput("rrst_waitreq", {31'b0, cpu_waitrequest}, 32'h1);
    checkOutput("rrst_wr_err", {31'b0, cpu_wr_err}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      idleCycle();
      checkOutput("rrst_no_strobe", {31'b0, cpu_readdatavalid}, 32'h0);
      checkOutput("rrst_no_done", {31'b0, jtag_done}, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
